seg7_scan_decoder: RTL and testbench

Receiving end of the seven-segment display path. Observes a time-multiplexed display bus (digit-select plus segment lines) and recovers the 4-bit hex value shown on each digit. Debounces each digit's segment pattern and publishes a full frame of recovered digits with a one-cycle valid strobe. Used for display loopback checking and for capturing external display modules on the calendar/clock board.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and glyph table for the seven-segment scan decoder.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

  // Entry i is the segment pattern that displays hex digit i
  localparam seg_t GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-nibble lookup; unknown patterns give value 0 and err=1.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_t    seg,
  output nibble_t value,
  output logic    err
);

  always_comb begin
    value = '0;
    err   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPHS[i]) begin
        value = nibble_t'(i);
        err   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment bus and publishes frames.
// Define SEG7_ACTIVE_LOW_EN for common-anode (active-low) an_i/seg_i.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_err_o,
  output logic                    frame_valid_o,
  output logic                    anomaly_o
);

  logic [NUM_DIGITS-1:0] an_r;
  seg_t                  seg_r;
  logic [NUM_DIGITS-1:0] lat_an;
  seg_t                  lat_seg;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_upd;
  state_t                state;
  state_t                state_next;
  logic                  load;
  logic                  accept;
  logic                  an_onehot;
  logic                  an_bad;
  logic                  same;
  nibble_t               dec_value;
  logic                  dec_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      an_r  <= '0;
      seg_r <= '0;
    end else begin
`ifdef SEG7_ACTIVE_LOW_EN
      an_r  <= ~an_i;
      seg_r <= ~seg_i;
`else
      an_r  <= an_i;
      seg_r <= seg_i;
`endif
    end
  end

  assign an_onehot = $onehot(an_r);
  assign an_bad    = (an_r != '0) && !an_onehot;
  assign same      = (an_r == lat_an) && (seg_r == lat_seg);
  assign seen_upd  = seen | an_r;

  seg7_glyph_decode u_decode (
    .seg   (seg_r),
    .value (dec_value),
    .err   (dec_err)
  );

  // A new one-hot pattern always restarts the count at 1, from any state
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (an_onehot) load = 1'b1;
      end
      TRACK: begin
        if (!same) begin
          if (an_onehot) load = 1'b1;
          else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (cnt >= CNT_W'(STABLE_CYCLES - 1)) begin
          accept     = 1'b1;
          cnt_next   = CNT_W'(STABLE_CYCLES);
          state_next = HOLD;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!same) begin
          if (an_onehot) load = 1'b1;
          else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (load) begin
      cnt_next = CNT_W'(1);
      if (STABLE_CYCLES == 1) begin
        accept     = 1'b1;
        state_next = HOLD;
      end else begin
        state_next = TRACK;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_an        <= '0;
      lat_seg       <= '0;
      seen          <= '0;
      digits_o      <= '0;
      digit_err_o   <= '0;
      frame_valid_o <= 1'b0;
      anomaly_o     <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      frame_valid_o <= 1'b0;
      anomaly_o     <= an_bad;
      if (load) begin
        lat_an  <= an_r;
        lat_seg <= seg_r;
      end
      if (accept) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (an_r[k]) begin
            digits_o[4*k +: 4] <= dec_value;
            digit_err_o[k]     <= dec_err;
          end
        end
        // The completing digit is consumed by this frame, not carried into the next
        if (&seen_upd) begin
          frame_valid_o <= 1'b1;
          seen          <= '0;
        end else begin
          seen <= seen_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized self-checking bench for seg7_scan_decoder against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an_i;
  logic [6:0]  seg_i;
  logic [31:0] digits_o;
  logic [7:0]  digit_err_o;
  logic        frame_valid_o;
  logic        anomaly_o;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .NUM_DIGITS    (8),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .an_i          (an_i),
    .seg_i         (seg_i),
    .digits_o      (digits_o),
    .digit_err_o   (digit_err_o),
    .frame_valid_o (frame_valid_o),
    .anomaly_o     (anomaly_o)
  );

  logic [6:0] glyphs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int test_count    = 0;
  int fail_count    = 0;
  int frame_count   = 0;
  int anomaly_count = 0;

  // Reference model: a digit is accepted when a run of identical one-hot samples reaches STABLE
  logic [7:0] pend_an, prev_an;
  logic [6:0] pend_seg, prev_seg;
  bit         prev_valid;
  int         run_len;
  logic [3:0] exp_val [8];
  logic [7:0] exp_err;
  logic [7:0] seen;
  logic       exp_frame;
  logic       exp_anom;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] expDigits();
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[4*k +: 4] = exp_val[k];
    return r;
  endfunction

  task automatic modelEdge(input bit r, input logic [7:0] an, input logic [6:0] seg);
    int idx;
    if (r) begin
      pend_an    = '0;
      pend_seg   = '0;
      prev_valid = 1'b0;
      run_len    = 0;
      seen       = '0;
      exp_err    = '0;
      exp_frame  = 1'b0;
      exp_anom   = 1'b0;
      for (int k = 0; k < 8; k++) exp_val[k] = '0;
    end else begin
      exp_frame = 1'b0;
      exp_anom  = (pend_an != 8'h00) && ($countones(pend_an) != 1);
      if (prev_valid && pend_an == prev_an && pend_seg == prev_seg) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_len = 1;
      end
      prev_an    = pend_an;
      prev_seg   = pend_seg;
      prev_valid = 1'b1;
      if ($countones(pend_an) == 1 && run_len == STABLE) begin
        idx = 0;
        for (int k = 0; k < 8; k++) if (pend_an[k]) idx = k;
        exp_val[idx] = 4'h0;
        exp_err[idx] = 1'b1;
        for (int g = 0; g < 16; g++) begin
          if (glyphs[g] == pend_seg) begin
            exp_val[idx] = 4'(g);
            exp_err[idx] = 1'b0;
          end
        end
        seen[idx] = 1'b1;
        if (seen == 8'hFF) begin
          exp_frame = 1'b1;
          seen      = '0;
        end
      end
      pend_an  = an;
      pend_seg = seg;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg, input bit r);
`ifdef SEG7_ACTIVE_LOW_EN
    an_i  = ~an;
    seg_i = ~seg;
`else
    an_i  = an;
    seg_i = seg;
`endif
    rst = r;
    @(posedge clk);
    modelEdge(r, an, seg);
    #1;
    checkOutput("digits", digits_o, expDigits());
    checkOutput("digit_err", 32'(digit_err_o), 32'(exp_err));
    checkOutput("frame_valid", 32'(frame_valid_o), 32'(exp_frame));
    checkOutput("anomaly", 32'(anomaly_o), 32'(exp_anom));
    if (frame_valid_o) frame_count++;
    if (anomaly_o) anomaly_count++;
  endtask

  initial begin
    logic [7:0] an;
    logic [6:0] seg;
    int         pick;
    int         len;

    // Full scan of digits 0..7
    repeat (2) applyStimulus(8'h00, 7'h00, 1'b1);
    checkOutput("reset_digits", digits_o, 32'h0);
    checkOutput("reset_err", 32'(digit_err_o), 32'h0);
    frame_count = 0;
    for (int d = 0; d < 8; d++) repeat (6) applyStimulus(8'(1 << d), glyphs[d], 1'b0);
    checkOutput("scan_digits", digits_o, 32'h7654_3210);
    checkOutput("scan_err", 32'(digit_err_o), 32'h0);
    checkOutput("scan_frames", 32'(frame_count), 32'd1);

    // Toggling segments never settle long enough
    applyStimulus(8'h00, 7'h00, 1'b1);
    frame_count = 0;
    for (int i = 0; i < 6; i++) begin
      repeat (2) applyStimulus(8'h04, 7'h5B, 1'b0);
      repeat (2) applyStimulus(8'h04, 7'h4F, 1'b0);
    end
    repeat (3) applyStimulus(8'h00, 7'h00, 1'b0);
    checkOutput("toggle_digit2", 32'(digits_o[11:8]), 32'h0);
    checkOutput("toggle_frames", 32'(frame_count), 32'd0);

    // Blank pattern is an illegal glyph
    repeat (6) applyStimulus(8'h20, 7'h00, 1'b0);
    checkOutput("blank_value", 32'(digits_o[23:20]), 32'h0);
    checkOutput("blank_err", 32'(digit_err_o[5]), 32'h1);

    // Two digit selects at once, then recovery
    anomaly_count = 0;
    repeat (3) applyStimulus(8'h03, 7'h06, 1'b0);
    repeat (6) applyStimulus(8'h02, 7'h06, 1'b0);
    checkOutput("anomaly_pulses", 32'(anomaly_count), 32'd3);
    checkOutput("resume_digit1", 32'(digits_o[7:4]), 32'h1);

    // Reset in the middle of tracking
    repeat (3) applyStimulus(8'h01, 7'h71, 1'b0);
    applyStimulus(8'h01, 7'h71, 1'b1);
    repeat (3) applyStimulus(8'h00, 7'h00, 1'b0);
    checkOutput("midreset_digits", digits_o, 32'h0);
    checkOutput("midreset_err", 32'(digit_err_o), 32'h0);
    frame_count = 0;
    for (int d = 1; d < 8; d++) repeat (6) applyStimulus(8'(1 << d), glyphs[d], 1'b0);
    checkOutput("midreset_seen", 32'(frame_count), 32'd0);

    // Glyph A on digit 0
    repeat (6) applyStimulus(8'h01, 7'h77, 1'b0);
    checkOutput("glyph_a", 32'(digits_o[3:0]), 32'hA);

    // Randomized holds
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 99));
      len  = int'($urandom_range(1, 7));
      if (pick < 70) begin
        an  = 8'(1 << $urandom_range(0, 7));
        seg = glyphs[$urandom_range(0, 15)];
      end else if (pick < 80) begin
        an  = 8'(1 << $urandom_range(0, 7));
        seg = 7'($urandom);
      end else if (pick < 88) begin
        an  = 8'($urandom);
        seg = 7'($urandom);
      end else if (pick < 95) begin
        an  = 8'h00;
        seg = 7'($urandom);
      end else begin
        applyStimulus(8'h00, 7'h00, 1'b1);
        continue;
      end
      repeat (len) applyStimulus(an, seg, 1'b0);
    end

    // Random-value full scans to exercise frame completion
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < 8; d++) repeat (5) applyStimulus(8'(1 << d), glyphs[$urandom_range(0, 15)], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
